// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - oversampling UART receiver with parity/framing checks and an output FIFO
// Define RX_BREAK_DETECT_EN to add the brk output and break-frame suppression.
module uart_rx_framed #(
    parameter int WIDTH     = 8,
    parameter int SAMPLES   = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_in,
    input  logic                   rd,
    output logic                   valid,
    output logic [WIDTH-1:0]       data,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun,
`ifdef RX_BREAK_DETECT_EN
    output logic                   brk,
`endif
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(SAMPLES);
    localparam int PW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + 2;
    localparam logic [CW-1:0] CNT_MID  = CW'(SAMPLES / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH
`ifdef RX_BREAK_DETECT_EN
        , S_BREAK
`endif
    } state_t;

    logic          sync1_q, sync2_q;
    logic [CW-1:0] filt_q, filt_d;
    logic          s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          stop_q, stop_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic          par_bit_q, par_bit_d;
    logic          ferr_q, ferr_d;
    logic          push, perr, par_calc;
    logic [EW-1:0] entry;
`ifdef RX_BREAK_DETECT_EN
    logic          brk_q, brk_d;
`endif

    // Saturating integrator: the line must dominate half a bit before s flips.
    always_comb begin
        filt_d = filt_q;
        if (sync2_q && filt_q != CNT_LAST)
            filt_d = filt_q + 1'b1;
        else if (!sync2_q && filt_q != '0)
            filt_d = filt_q - 1'b1;
    end
    assign s = filt_q[CW-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        pos_d     = pos_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
`ifdef RX_BREAK_DETECT_EN
        brk_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = S_START;
                    pos_d   = '0;
                    stop_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: if (cnt_q == CNT_MID) begin
                cnt_d   = '0;
                state_d = s ? S_IDLE : S_DATA;
            end
            S_DATA: if (cnt_q == CNT_LAST) begin
                shift_d[pos_q] = s;
                pos_d = pos_q + 1'b1;
                if (pos_q == PW'(WIDTH - 1))
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (cnt_q == CNT_LAST) begin
                par_bit_d = s;
                state_d   = S_STOP;
            end
            S_STOP: if (cnt_q == CNT_LAST) begin
                if (!s)
                    ferr_d = 1'b1;
                if (stop_q == 1'(STOP_BITS - 1))
                    state_d = S_PUSH;
                else
                    stop_d = 1'b1;
`ifdef RX_BREAK_DETECT_EN
                if (!stop_q && !s && shift_q == '0 && (PARITY == 0 || !par_bit_q)) begin
                    brk_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BREAK;
                end
`endif
            end
            S_PUSH: begin
                push    = 1'b1;
                state_d = S_IDLE;
            end
`ifdef RX_BREAK_DETECT_EN
            S_BREAK: begin
                if (!s)
                    cnt_d = '0;
                else if (cnt_q == CNT_LAST)
                    state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign par_calc = (^shift_q) ^ par_bit_q;
    always_comb begin
        perr = 1'b0;
        if (PARITY == 1)
            perr = par_calc;
        else if (PARITY == 2)
            perr = !par_calc;
    end
    assign entry = {shift_q, perr, ferr_q};

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [EW-1:0] head_q, head_d;
    logic          overrun_q, overrun_d;
    logic          pop, push_ok;

    always_comb begin
        pop       = rd && (count_q != '0);
        push_ok   = push && ((count_q != FULL) || pop);
        wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push_ok && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push_ok)
            count_d = count_q - 1'b1;
        overrun_d = overrun_q;
        if (pop)
            overrun_d = 1'b0;
        if (push && !push_ok)
            overrun_d = 1'b1;
        // When the FIFO drains to empty in this cycle, the new entry bypasses the array.
        head_d = '0;
        if (count_d != '0)
            head_d = (push_ok && count_q == {{AW{1'b0}}, pop}) ? entry : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            filt_q    <= '1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pos_q     <= '0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            ferr_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            overrun_q <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
            brk_q     <= 1'b0;
`endif
        end else begin
            sync1_q   <= rx_in;
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            ferr_q    <= ferr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            overrun_q <= overrun_d;
`ifdef RX_BREAK_DETECT_EN
            brk_q     <= brk_d;
`endif
        end
    end

    assign valid = (count_q != '0);
    assign count = count_q;
    assign {data, parity_err, frame_err} = head_q;
    assign overrun = overrun_q;
`ifdef RX_BREAK_DETECT_EN
    assign brk = brk_q;
`endif
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - directed bench for uart_rx_framed (8N1 instance and 8E2 instance)
module tb_uart_rx_framed;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rd0 = 1'b0, rd1 = 1'b0;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1;
    logic [7:0] data0, data1;
    logic [2:0] count0, count1;
    int         n_checks = 0;
    int         n_pass = 0;
`ifdef RX_BREAK_DETECT_EN
    logic       brk0, brk1;
    int         brk_seen = 0;
    always @(negedge clk) if (brk0) brk_seen++;
`endif

    always #5 clk = ~clk;

    uart_rx_framed #(.WIDTH(8), .SAMPLES(16), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .rx_in(rx0), .rd(rd0), .valid(valid0), .data(data0),
        .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0),
`ifdef RX_BREAK_DETECT_EN
        .brk(brk0),
`endif
        .count(count0));

    uart_rx_framed #(.WIDTH(8), .SAMPLES(16), .PARITY(1), .STOP_BITS(2), .DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .rx_in(rx1), .rd(rd1), .valid(valid1), .data(data1),
        .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1),
`ifdef RX_BREAK_DETECT_EN
        .brk(brk1),
`endif
        .count(count1));

    task automatic send_bits(input int which, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx0 = bits[i]; else rx1 = bits[i];
            repeat (16) @(negedge clk);
        end
        rx0 = 1'b1;
        rx1 = 1'b1;
    endtask

    task automatic send0(input logic [7:0] d, input logic stop);
        send_bits(0, {2'b11, stop, d, 1'b0}, 10);
    endtask

    task automatic send1(input logic [7:0] d, input logic par, input logic s1, input logic s2);
        send_bits(1, {s2, s1, par, d, 1'b0}, 12);
    endtask

    task automatic pop(input int which);
        if (which == 0) rd0 = 1'b1; else rd1 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({valid0, data0, perr0, ferr0, ovr0, count0} !== 14'd0)
            $display("FAIL reset0 got %b want 0", {valid0, data0, perr0, ferr0, ovr0, count0});
        else n_pass++;
        n_checks++;
        if ({valid1, data1, perr1, ferr1, ovr1, count1} !== 14'd0)
            $display("FAIL reset1 got %b want 0", {valid1, data1, perr1, ferr1, ovr1, count1});
        else n_pass++;
        pop(0);
        n_checks++;
        if ({valid0, count0, ovr0} !== 5'd0)
            $display("FAIL rd_empty got valid=%b count=%0d ovr=%b want 0/0/0", valid0, count0, ovr0);
        else n_pass++;
    endtask

    task automatic test_basic;
        send0(8'hA5, 1'b1);
        send0(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        n_checks++;
        if ({valid0, count0, data0, perr0, ferr0} !== {1'b1, 3'd2, 8'hA5, 2'b00})
            $display("FAIL basic_head got v=%b c=%0d d=%h pe=%b fe=%b want 1/2/a5/0/0",
                     valid0, count0, data0, perr0, ferr0);
        else n_pass++;
        pop(0);
        n_checks++;
        if ({valid0, count0, data0} !== {1'b1, 3'd1, 8'h3C})
            $display("FAIL basic_pop1 got v=%b c=%0d d=%h want 1/1/3c", valid0, count0, data0);
        else n_pass++;
        pop(0);
        n_checks++;
        if ({valid0, count0} !== 4'd0)
            $display("FAIL basic_pop2 got v=%b c=%0d want 0/0", valid0, count0);
        else n_pass++;
    endtask

    task automatic test_parity;
        send1(8'h07, 1'b1, 1'b1, 1'b1);
        send1(8'h07, 1'b0, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        n_checks++;
        if ({count1, data1, perr1, ferr1} !== {3'd2, 8'h07, 2'b00})
            $display("FAIL parity_ok got c=%0d d=%h pe=%b fe=%b want 2/07/0/0", count1, data1, perr1, ferr1);
        else n_pass++;
        pop(1);
        n_checks++;
        if ({count1, data1, perr1, ferr1} !== {3'd1, 8'h07, 2'b10})
            $display("FAIL parity_bad got c=%0d d=%h pe=%b fe=%b want 1/07/1/0", count1, data1, perr1, ferr1);
        else n_pass++;
        pop(1);
    endtask

    task automatic test_stop2;
        send1(8'h55, 1'b0, 1'b1, 1'b0);
        repeat (16) @(negedge clk);
        n_checks++;
        if ({count1, data1, perr1, ferr1} !== {3'd1, 8'h55, 2'b01})
            $display("FAIL stop2_low got c=%0d d=%h pe=%b fe=%b want 1/55/0/1", count1, data1, perr1, ferr1);
        else n_pass++;
        pop(1);
        n_checks++;
        if (count1 !== 3'd0)
            $display("FAIL stop2_drain got c=%0d want 0", count1);
        else n_pass++;
    endtask

    task automatic test_glitch;
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if ({valid0, count0} !== 4'd0)
            $display("FAIL glitch got v=%b c=%0d want 0/0", valid0, count0);
        else n_pass++;
        rx0 = 1'b0;
        repeat (10) @(negedge clk);
        rx0 = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if ({valid0, count0} !== 4'd0)
            $display("FAIL false_start got v=%b c=%0d want 0/0", valid0, count0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 5; i++) send0(8'(i), 1'b1);
        repeat (8) @(negedge clk);
        n_checks++;
        if ({count0, ovr0, data0} !== {3'd4, 1'b1, 8'h01})
            $display("FAIL overrun got c=%0d ovr=%b d=%h want 4/1/01", count0, ovr0, data0);
        else n_pass++;
        for (int i = 2; i <= 4; i++) begin
            pop(0);
            n_checks++;
            if ({count0, ovr0, data0} !== {3'(5 - i), 1'b0, 8'(i)})
                $display("FAIL drain%0d got c=%0d ovr=%b d=%h want %0d/0/%h", i, count0, ovr0, data0, 5 - i, i);
            else n_pass++;
        end
        pop(0);
        n_checks++;
        if ({valid0, count0} !== 4'd0)
            $display("FAIL drain_end got v=%b c=%0d want 0/0", valid0, count0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        rx0 = 1'b0;
        repeat (16) @(negedge clk);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        n_checks++;
        if ({valid0, count0} !== 4'd0)
            $display("FAIL reset_mid got v=%b c=%0d want 0/0", valid0, count0);
        else n_pass++;
        send0(8'h12, 1'b1);
        repeat (8) @(negedge clk);
        n_checks++;
        if ({count0, data0, perr0, ferr0} !== {3'd1, 8'h12, 2'b00})
            $display("FAIL after_reset got c=%0d d=%h pe=%b fe=%b want 1/12/0/0", count0, data0, perr0, ferr0);
        else n_pass++;
        pop(0);
    endtask

    task automatic test_break;
`ifdef RX_BREAK_DETECT_EN
        send_bits(0, 12'h000, 12);
        repeat (60) @(negedge clk);
        n_checks++;
        if ({brk_seen, count0} !== {32'd1, 3'd0})
            $display("FAIL break got pulses=%0d c=%0d want 1/0", brk_seen, count0);
        else n_pass++;
        send0(8'h5A, 1'b1);
        repeat (8) @(negedge clk);
        n_checks++;
        if ({count0, data0, ferr0} !== {3'd1, 8'h5A, 1'b0})
            $display("FAIL after_break got c=%0d d=%h fe=%b want 1/5a/0", count0, data0, ferr0);
        else n_pass++;
        pop(0);
`else
        send_bits(0, 12'hC00, 10);
        repeat (40) @(negedge clk);
        n_checks++;
        if ({count0, data0, perr0, ferr0} !== {3'd1, 8'h00, 2'b01})
            $display("FAIL zero_frame got c=%0d d=%h pe=%b fe=%b want 1/00/0/1", count0, data0, perr0, ferr0);
        else n_pass++;
        pop(0);
        n_checks++;
        if (count0 !== 3'd0)
            $display("FAIL zero_drain got c=%0d want 0", count0);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_stop2;
        test_glitch;
        test_back_to_back;
        test_reset_mid_frame;
        test_break;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
